// File: rtl/seq_div16_pkg.sv
// Shared datapath definitions for the sequential restoring divider.
package seq_div16_pkg;

    localparam int unsigned DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Quotient reported for a zero divisor.
    localparam logic [DATA_W-1:0] DIV_ZERO_Q = '1;

endpackage

// File: rtl/seq_div16_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] dsr,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;

    // A non-negative WIDTH+1-bit difference means the divisor fits; the kept
    // remainder is then below the divisor, so WIDTH bits always suffice.
    always_comb begin
        shifted = {rem_in, bit_in};
        q_bit   = (shifted >= {1'b0, dsr});
        rem_out = q_bit ? (shifted[WIDTH-1:0] - dsr) : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_div16.sv
// Multi-cycle restoring divider, one quotient bit per cycle, signed or unsigned operands.
module seq_div16
    import seq_div16_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;
    logic [WIDTH-1:0]   dsr_q, dsr_d;
    logic [WIDTH-1:0]   prem_q, prem_d;
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;
    logic [WIDTH-1:0]   quotient_d, remainder_d;
    logic               busy_d, done_d, dbz_d;

    logic [WIDTH-1:0]   step_rem;
    logic               step_q;

    function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
        return (~x) + WIDTH'(1);
    endfunction

    // Two's-complement magnitude; -2^(WIDTH-1) maps onto itself read as unsigned.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
        return (sgn && x[WIDTH-1]) ? neg(x) : x;
    endfunction

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_in  (prem_q),
        .bit_in  (dvd_q[WIDTH-1]),
        .dsr     (dsr_q),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            dsr_q       <= '0;
            prem_q      <= '0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dvd_q       <= dvd_d;
            dsr_q       <= dsr_d;
            prem_q      <= prem_d;
            qneg_q      <= qneg_d;
            rneg_q      <= rneg_d;
            quotient    <= quotient_d;
            remainder   <= remainder_d;
            busy        <= busy_d;
            done        <= done_d;
            div_by_zero <= dbz_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dvd_d       = dvd_q;
        dsr_d       = dsr_q;
        prem_d      = prem_q;
        qneg_d      = qneg_q;
        rneg_d      = rneg_q;
        quotient_d  = quotient;
        remainder_d = remainder;
        dbz_d       = div_by_zero;
        busy_d      = 1'b0;
        done_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    if (divisor == '0) begin
                        // Package constant is all ones; replicate so any WIDTH stays all ones.
                        quotient_d  = {WIDTH{DIV_ZERO_Q[0]}};
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        state_d     = DONE;
                    end else begin
                        dvd_d   = mag(dividend, is_signed);
                        dsr_d   = mag(divisor, is_signed);
                        qneg_d  = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        rneg_d  = is_signed & dividend[WIDTH-1];
                        prem_d  = '0;
                        cnt_d   = CNT_W'(WIDTH);
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                busy_d = 1'b1;
                prem_d = step_rem;
                dvd_d  = {dvd_q[WIDTH-2:0], step_q};
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                busy_d      = 1'b1;
                quotient_d  = qneg_q ? neg(dvd_q) : dvd_q;
                remainder_d = rneg_q ? neg(prem_q) : prem_q;
                dbz_d       = 1'b0;
                state_d     = DONE;
            end
            DONE: begin
                busy_d  = 1'b1;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
